// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, register offsets and STAT bit positions for dbus_uart_tx
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int unsigned REG_DATA = 0;
    localparam int unsigned REG_STAT = 4;
    localparam int unsigned REG_DIV  = 8;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_PAR_EN  = 8;

    // FIFO occupancy shown in a 4-bit field, pinned at 15 for deep FIFOs
    function automatic logic [3:0] sat_nibble(input int unsigned v);
        return (v > 15) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/dbus_uart_tx_if.sv
// rtl/dbus_uart_tx_if.sv - data-memory bus slice seen by the UART register window
interface dbus_uart_tx_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] i_Addr;
    logic                  i_WrEnable;
    logic [DATA_WIDTH-1:0] i_WrData;
    logic [DATA_WIDTH-1:0] o_RdData;

    modport master (output i_Addr, output i_WrEnable, output i_WrData, input  o_RdData);
    modport slave  (input  i_Addr, input  i_WrEnable, input  i_WrData, output o_RdData);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO feeding the UART shifter
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // a push into a full FIFO is still accepted when a pop frees a slot in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // storage array, no reset needed since reads are gated by count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dbus_uart_tx.sv
// rtl/dbus_uart_tx.sv - memory-mapped 8N1 UART transmitter; UART_TX_PARITY_EN adds an even parity bit
module dbus_uart_tx
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'('h210),
    parameter int                    FIFO_DEPTH      = 8,
    parameter int                    DEFAULT_DIVISOR = 434
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    dbus_uart_tx_if.slave bus,
    output logic          o_Tx,
    output logic          o_Irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_DATA = ADDR_WIDTH'(REG_DATA);
    localparam logic [ADDR_WIDTH-1:0] OFF_STAT = ADDR_WIDTH'(REG_STAT);
    localparam logic [ADDR_WIDTH-1:0] OFF_DIV  = ADDR_WIDTH'(REG_DIV);

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word_off;
    logic                  hit_data, hit_stat, hit_div;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]            fifo_dout;
    logic [CW-1:0]         fifo_count;
    logic [15:0]           div_q;
    logic [15:0]           reload;
    logic                  ovf_q;
    logic [8:0]            stat;
    tx_state_t             state;
    logic [15:0]           baud_cnt;
    logic                  bit_done;
    logic [7:0]            shift_q;
    logic [2:0]            bit_idx;
`ifdef UART_TX_PARITY_EN
    logic                  par_q;
`endif
    logic                  unused_bits;

    // addresses below BASE_ADDR wrap to a large offset and miss every register
    assign offset      = bus.i_Addr - BASE_ADDR;
    assign word_off    = {offset[ADDR_WIDTH-1:2], 2'b00};
    assign hit_data    = (word_off == OFF_DATA);
    assign hit_stat    = (word_off == OFF_STAT);
    assign hit_div     = (word_off == OFF_DIV);
    assign unused_bits = &{1'b0, offset[1:0], bus.i_WrData[DATA_WIDTH-1:16]};

    assign fifo_push = bus.i_WrEnable && hit_data;
    assign bit_done  = (baud_cnt == 16'd0);
    assign fifo_pop  = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));
    // divisors below 2 run as 2 so a bit always spans at least two clocks
    assign reload    = (div_q < 16'd2) ? 16'd1 : div_q - 16'd1;
    assign o_Irq     = fifo_empty && (state == IDLE);

    uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_Clock),
        .rst_n (i_Reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.i_WrData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // divisor register and sticky overflow flag
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            div_q <= 16'(DEFAULT_DIVISOR);
            ovf_q <= 1'b0;
        end else begin
            if (bus.i_WrEnable && hit_div) div_q <= bus.i_WrData[15:0];
            if (fifo_push && fifo_full && !fifo_pop)
                ovf_q <= 1'b1;
            else if (bus.i_WrEnable && hit_stat && bus.i_WrData[STAT_OVF])
                ovf_q <= 1'b0;
        end
    end

    // transmit FSM: one state step per bit period, line level registered
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            shift_q  <= '0;
            bit_idx  <= '0;
            o_Tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else if (state != IDLE && !bit_done) begin
            baud_cnt <= baud_cnt - 16'd1;
        end else begin
            case (state)
                IDLE, STOP: begin
                    if (!fifo_empty) begin
                        shift_q  <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                        par_q    <= ^fifo_dout;
`endif
                        baud_cnt <= reload;
                        o_Tx     <= 1'b0;
                        state    <= START;
                    end else begin
                        o_Tx  <= 1'b1;
                        state <= IDLE;
                    end
                end
                START: begin
                    o_Tx     <= shift_q[0];
                    shift_q  <= shift_q >> 1;
                    bit_idx  <= 3'd0;
                    baud_cnt <= reload;
                    state    <= DATA;
                end
                DATA: begin
                    baud_cnt <= reload;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        o_Tx  <= par_q;
                        state <= PARITY;
`else
                        o_Tx  <= 1'b1;
                        state <= STOP;
`endif
                    end else begin
                        o_Tx    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                PARITY: begin
                    baud_cnt <= reload;
                    o_Tx     <= 1'b1;
                    state    <= STOP;
                end
                default: begin
                    o_Tx  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // status word and combinational read mux
    always_comb begin
        stat                            = '0;
        stat[STAT_BUSY]                 = (state != IDLE);
        stat[STAT_FULL]                 = fifo_full;
        stat[STAT_EMPTY]                = fifo_empty;
        stat[STAT_OVF]                  = ovf_q;
        stat[STAT_CNT_LSB+3:STAT_CNT_LSB] = sat_nibble(32'(fifo_count));
`ifdef UART_TX_PARITY_EN
        stat[STAT_PAR_EN]               = 1'b1;
`endif
        bus.o_RdData = '0;
        if (hit_stat)     bus.o_RdData[8:0]  = stat;
        else if (hit_div) bus.o_RdData[15:0] = div_q;
    end
endmodule

// File: tb/tb_dbus_uart_tx.sv
// tb/tb_dbus_uart_tx.sv - directed self-checking bench for dbus_uart_tx
module tb_dbus_uart_tx;
    localparam logic [9:0] A_DATA = 10'h210;
    localparam logic [9:0] A_STAT = 10'h214;
    localparam logic [9:0] A_DIV  = 10'h218;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PB    = 32'h100;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PB    = 32'h000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx, irq;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    dbus_uart_tx_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    dbus_uart_tx dut (
        .i_Clock (clk),
        .i_Reset (rst_n),
        .bus     (bus),
        .o_Tx    (tx),
        .o_Irq   (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic store(input logic [9:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.i_Addr     = addr;
        bus.i_WrData   = data;
        bus.i_WrEnable = 1'b1;
        @(posedge clk);
        #1;
        bus.i_WrEnable = 1'b0;
        bus.i_Addr     = A_STAT;
    endtask

    task automatic read_chk(input string tag, input logic [9:0] addr, input logic [31:0] exp);
        bus.i_Addr = addr;
        #1;
        check(tag, bus.o_RdData, exp);
        bus.i_Addr = A_STAT;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst tx", tx, 1);
        check("rst irq", irq, 1);
        read_chk("rst stat", A_STAT, 32'h04 | PB);
        read_chk("rst div", A_DIV, 32'd434);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0)               return 1'b0;
        if (k <= 8)               return b[k-1];
        if (k == 9 && NBITS == 11) return ^b;
        return 1'b1;
    endfunction

    // called on the first sample of a start bit; returns on the first sample after the frame
    task automatic frame_chk(input string tag, input logic [7:0] b, input int div);
        logic [15:0] grp;
        logic        e;
        for (int k = 0; k < NBITS; k++) begin
            grp = '0;
            for (int c = 0; c < div; c++) begin
                grp[c] = tx;
                @(posedge clk);
                #1;
            end
            e = frame_bit(b, k);
            check($sformatf("%s bit%0d", tag, k), {16'h0, grp}, e ? ((32'd1 << div) - 1) : 32'd0);
        end
    endtask

    initial begin
        bus.i_Addr     = A_STAT;
        bus.i_WrData   = '0;
        bus.i_WrEnable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("por tx", tx, 1);
        check("por irq", irq, 1);
        read_chk("por stat", A_STAT, 32'h04 | PB);
        read_chk("por div", A_DIV, 32'd434);
        @(negedge clk);
        rst_n = 1'b1;

        // reset in the middle of an all-zero frame
        store(A_DIV, 32'd4);
        store(A_DATA, 32'h00);
        repeat (10) @(posedge clk);
        do_reset();

        // single 0x55 frame at DIV=4
        store(A_DIV, 32'd4);
        read_chk("div rb", A_DIV, 32'd4);
        store(A_DATA, 32'h55);
        check("pre tx", tx, 1);
        check("pre irq", irq, 0);
        @(posedge clk);
        #1;
        read_chk("busy stat", A_STAT, 32'h05 | PB);
        check("busy irq", irq, 0);
        frame_chk("f55", 8'h55, 4);
        check("post irq", irq, 1);
        check("post tx", tx, 1);
        read_chk("post stat", A_STAT, 32'h04 | PB);

        // fill, overflow and clear at DIV=2
        do_reset();
        store(A_DIV, 32'd2);
        for (int i = 1; i <= 9; i++) store(A_DATA, i);
        read_chk("full stat", A_STAT, 32'h83 | PB);
        store(A_DATA, 32'h0A);
        read_chk("ovf stat", A_STAT, 32'h8B | PB);
        store(A_STAT, 32'h08);
        read_chk("clr stat", A_STAT, 32'h83 | PB);

        // back-to-back frames with no idle gap
        do_reset();
        store(A_DIV, 32'd2);
        store(A_DATA, 32'hA5);
        store(A_DATA, 32'h3C);
        read_chk("b2b stat1", A_STAT, 32'h11 | PB);
        frame_chk("fA5", 8'hA5, 2);
        read_chk("b2b stat2", A_STAT, 32'h05 | PB);
        frame_chk("f3C", 8'h3C, 2);
        check("b2b irq", irq, 1);
        read_chk("b2b stat3", A_STAT, 32'h04 | PB);

        // window boundaries
        read_chk("rd +12", 10'h21C, 32'h0);
        read_chk("rd 200", 10'h200, 32'h0);
        read_chk("rd data", A_DATA, 32'h0);
        store(10'h200, 32'h41);
        read_chk("oob stat", A_STAT, 32'h04 | PB);
        check("oob irq", irq, 1);
        repeat (3) @(posedge clk);
        #1;
        check("oob tx", tx, 1);

        // divisor below two runs as two
        store(A_DIV, 32'd0);
        store(A_DATA, 32'h00);
        @(posedge clk);
        #1;
        frame_chk("div0", 8'h00, 2);

`ifdef UART_TX_PARITY_EN
        store(A_DIV, 32'd3);
        store(A_DATA, 32'h07);
        @(posedge clk);
        #1;
        frame_chk("f07", 8'h07, 3);
        check("par irq", irq, 1);
        store(A_DATA, 32'h03);
        @(posedge clk);
        #1;
        frame_chk("f03", 8'h03, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
